// File: rtl/nco_spi_pkg.sv
// Shared constants and state encoding for the NCO SPI initiator.
package nco_spi_pkg;

   localparam int SPI_BYTE_W            = 8;
   localparam int CLKS_PER_HALF_BIT_MIN = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_CS_SETUP = 3'd1;
   localparam state_t ST_SHIFT    = 3'd2;
   localparam state_t ST_BYTE_GAP = 3'd3;
   localparam state_t ST_CS_HOLD  = 3'd4;
   localparam state_t ST_CS_GAP   = 3'd5;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/nco_spi_sync2.sv
// Two-flop synchronizer for the MISO input; resets to 0.
module nco_spi_sync2 (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nco_spi_master.sv
// Byte-wide SPI mode-0 initiator for NCO frames; frames delimited by i_tx_last.
// Optional MISO capture is enabled by defining NCO_SPI_MISO_CAPTURE_EN.
//
// state       | meaning
// IDLE        | CS high, waiting for first byte of a frame
// CS_SETUP    | CS low, bit7 on MOSI, SCLK still low
// SHIFT       | toggling SCLK, 8 bits MSB first
// BYTE_GAP    | mid-frame, SCLK low, CS low, waiting for next byte
// CS_HOLD     | CS held low after last SCLK fall
// CS_GAP      | CS high, minimum inter-frame time
module nco_spi_master
   import nco_spi_pkg::*;
#(
   parameter int CLKS_PER_HALF_BIT = 4,
   parameter int CS_SETUP_CLKS     = 4,
   parameter int CS_HOLD_CLKS      = 4,
   parameter int CS_IDLE_CLKS      = 8
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic [SPI_BYTE_W-1:0] i_tx_byte,
   input  logic                  i_tx_valid,
   input  logic                  i_tx_last,
   output logic                  o_tx_ready,
   output logic                  o_busy,
   output logic                  o_byte_done,
   output logic                  o_SCLK,
   output logic                  o_CS,
   output logic                  o_MOSI,
   input  logic                  i_MISO,
   output logic [SPI_BYTE_W-1:0] o_rx_byte,
   output logic                  o_rx_valid
);

   localparam int MAXP  = max4(CLKS_PER_HALF_BIT, CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS);
   localparam int CNT_W = $clog2(MAXP) + 1;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(CLKS_PER_HALF_BIT - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CLKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE_CLKS - 1);

   state_t                  state_q, state_nx;
   logic [CNT_W-1:0]        hb_cnt, tmr;
   logic [2:0]              bit_cnt;
   logic                    sclk_q, last_q, byte_done_q, rdy_en_q;
   logic [SPI_BYTE_W-1:0]   tx_sr;
   logic                    hb_wrap, fall, fall8, accept;

   assign hb_wrap = (state_q == ST_SHIFT) && (hb_cnt == H_LAST);
   assign fall    = hb_wrap && sclk_q;
   assign fall8   = fall && (bit_cnt == 3'd7);
   assign accept  = i_tx_valid && o_tx_ready;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= ST_IDLE;
      else            state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         ST_IDLE:     if (accept)      state_nx = ST_CS_SETUP;
         ST_CS_SETUP: if (tmr == '0)   state_nx = ST_SHIFT;
         ST_SHIFT:    if (fall8)       state_nx = last_q ? ST_CS_HOLD : ST_BYTE_GAP;
         ST_BYTE_GAP: if (accept)      state_nx = ST_SHIFT;
         ST_CS_HOLD:  if (tmr == '0)   state_nx = ST_CS_GAP;
         ST_CS_GAP:   if (tmr == '0)   state_nx = ST_IDLE;
         default:                      state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      o_tx_ready  = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_BYTE_GAP));
      o_busy      = (state_q != ST_IDLE);
      o_CS        = !((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                      (state_q == ST_BYTE_GAP) || (state_q == ST_CS_HOLD));
      o_SCLK      = sclk_q;
      o_MOSI      = tx_sr[SPI_BYTE_W-1];
      o_byte_done = byte_done_q;
   end

   // Half-bit counter and SCLK only move in SHIFT; every entry to SHIFT starts a fresh low phase.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hb_cnt      <= '0;
         sclk_q      <= 1'b0;
         bit_cnt     <= 3'd0;
         tmr         <= '0;
         tx_sr       <= '0;
         last_q      <= 1'b0;
         byte_done_q <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         rdy_en_q    <= 1'b1;
         byte_done_q <= fall8;
         if (state_q == ST_SHIFT) begin
            hb_cnt <= hb_wrap ? '0 : hb_cnt + CNT_W'(1);
            if (hb_wrap) sclk_q <= ~sclk_q;
            if (fall)    bit_cnt <= bit_cnt + 3'd1;
         end else begin
            hb_cnt  <= '0;
            sclk_q  <= 1'b0;
            bit_cnt <= 3'd0;
         end
         if (accept) begin
            tx_sr  <= i_tx_byte;
            last_q <= i_tx_last;
         end else if (fall && (bit_cnt != 3'd7)) begin
            tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
         end
         if (state_nx != state_q) begin
            case (state_nx)
               ST_CS_SETUP: tmr <= SETUP_LAST;
               ST_CS_HOLD:  tmr <= HOLD_LAST;
               ST_CS_GAP:   tmr <= GAP_LAST;
               default:     tmr <= '0;
            endcase
         end else if (tmr != '0) begin
            tmr <= tmr - CNT_W'(1);
         end
      end
   end

`ifdef NCO_SPI_MISO_CAPTURE_EN
   logic                  miso_s, rx_valid_q;
   logic [SPI_BYTE_W-1:0] rx_sr, rx_byte_q;

   nco_spi_sync2 u_miso_sync (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .d         (i_MISO),
      .q         (miso_s)
   );

   // Last cycle of each SCLK-high phase is the same cycle the fall is scheduled.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_sr      <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= fall8;
         if (fall)  rx_sr     <= {rx_sr[SPI_BYTE_W-2:0], miso_s};
         if (fall8) rx_byte_q <= {rx_sr[SPI_BYTE_W-2:0], miso_s};
      end
   end

   assign o_rx_byte  = rx_byte_q;
   assign o_rx_valid = rx_valid_q;
`else
   logic unused_miso;
   assign unused_miso = i_MISO;
   assign o_rx_byte   = '0;
   assign o_rx_valid  = 1'b0;
`endif

endmodule
